// File: rtl/aes128_cbc_decrypt.sv
// ---------------------------------------------------------------------------
// aes128_cbc_decrypt
//   AES-128 inverse cipher with CBC chaining. The core is iterative and runs
//   continuously with no handshake. Each block takes 23 clocks:
//     LOAD (1), EXPAND (10), TURN (1), ARK (1), ROUND (9), FINAL (1).
//   The key schedule is computed on the fly. It is first run forward from
//   the cipher key up to RK10, then walked backwards one round key per
//   clock while the state is decrypted.
//
// Ports
//   clk         : clock, rising edge
//   rst_n       : synchronous active-low reset (clears plaintext, loads iv)
//   ciphertext  : ciphertext block C_i, sampled in LOAD
//   key         : AES-128 cipher key, sampled in LOAD
//   iv          : initialisation vector, sampled while rst_n = 0
//   plaintext   : registered InvCipher(C_i, key) ^ chain
//
// Byte order: bits [127:120] are state byte 0, column-major.
// ---------------------------------------------------------------------------
module aes128_cbc_decrypt (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] ciphertext,
    input  logic [127:0] key,
    input  logic [127:0] iv,
    output logic [127:0] plaintext
);

    typedef enum logic [2:0] {
        S_LOAD, S_EXPAND, S_TURN, S_ARK, S_ROUND, S_FINAL
    } state_t;

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777b_f26b6fc5_3001672b_fed7ab76,
        128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
        128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
        128'h04c723c3_1896059a_071280e2_eb27b275,
        128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
        128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
        128'hd0efaafb_434d3385_45f9027f_503c9fa8,
        128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
        128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
        128'h60814fdc_222a9088_46eeb814_de5e0bdb,
        128'he0323a0a_4906245c_c2d3ac62_9195e479,
        128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
        128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
        128'h703eb566_4803f60e_613557b9_86c11d9e,
        128'he1f89811_69d98e94_9b1e87e9_ce5528df,
        128'h8ca1890d_bfe64268_41992d0f_b054bb16
    };

    localparam logic [0:255][7:0] INV_SBOX = {
        128'h52096ad5_3036a538_bf40a39e_81f3d7fb,
        128'h7ce33982_9b2fff87_348e4344_c4dee9cb,
        128'h547b9432_a6c2233d_ee4c950b_42fac34e,
        128'h082ea166_28d924b2_765ba249_6d8bd125,
        128'h72f8f664_86689816_d4a45ccc_5d65b692,
        128'h6c704850_fdedb9da_5e154657_a78d9d84,
        128'h90d8ab00_8cbcd30a_f7e45805_b8b34506,
        128'hd02c1e8f_ca3f0f02_c1afbd03_01138a6b,
        128'h3a911141_4f67dcea_97f2cfce_f0b4e673,
        128'h96ac7422_e7ad3585_e2f937e8_1c75df6e,
        128'h47f11a71_1d29c589_6fb7620e_aa18be1b,
        128'hfc563e4b_c6d27920_9adbc0fe_78cd5af4,
        128'h1fdda833_8807c731_b1121059_2780ec5f,
        128'h60517fa9_19b54a0d_2de57a9f_93c99cef,
        128'ha0e03b4d_ae2af5b0_c8ebbb3c_83539961,
        128'h172b047e_ba77d626_e1691463_55210c7d
    };

    // Multiply by x in GF(2^8), poly 0x11B.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Divide by x: undoes xtime so rcon can be walked backwards.
    function automatic logic [7:0] inv_xtime(input logic [7:0] b);
        return b[0] ? ({1'b1, b[7:1]} ^ 8'h0d) : {1'b0, b[7:1]};
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127 - 8*(r + 4*((c + r) % 4)) -: 8] = s[127 - 8*(r + 4*c) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31 - 8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        return {inv_mix_col(s[127:96]), inv_mix_col(s[95:64]),
                inv_mix_col(s[63:32]),  inv_mix_col(s[31:0])};
    endfunction

    state_t        state_reg, state_next;
    logic [3:0]    cnt_reg, cnt_next;
    logic [127:0]  st_reg, st_next;
    logic [127:0]  c_lat_reg, c_lat_next;
    logic [127:0]  rk_reg, rk_next;
    logic [7:0]    rcon_reg, rcon_next;
    logic [127:0]  chain_reg, chain_next;
    logic [127:0]  pt_reg, pt_next;

    // InvSubBytes(InvShiftRows(st)) is shared by ROUND and FINAL.
    logic [127:0]  st_shifted;
    logic [127:0]  st_subbed;

    // Key schedule words of the current round key.
    logic [31:0]   w0, w1, w2, w3;
    logic [31:0]   fwd_rot, inv_rot;
    logic [31:0]   fwd_sub, inv_sub;
    logic [31:0]   inv_w3;
    logic [127:0]  rk_fwd, rk_inv;

    assign st_shifted = inv_shift_rows(st_reg);

    assign {w0, w1, w2, w3} = rk_reg;
    assign inv_w3  = w3 ^ w2;
    assign fwd_rot = {w3[23:0], w3[31:24]};
    assign inv_rot = {inv_w3[23:0], inv_w3[31:24]};

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_inv_sub
            assign st_subbed[127 - 8*gi -: 8] = INV_SBOX[st_shifted[127 - 8*gi -: 8]];
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_key_sub
            assign fwd_sub[31 - 8*gi -: 8] = SBOX[fwd_rot[31 - 8*gi -: 8]];
            assign inv_sub[31 - 8*gi -: 8] = SBOX[inv_rot[31 - 8*gi -: 8]];
        end
    endgenerate

    // Forward step RKn -> RKn+1 and backward step RKn+1 -> RKn.
    always_comb begin
        logic [31:0] f0, f1, f2;
        f0 = w0 ^ fwd_sub ^ {rcon_reg, 24'h0};
        f1 = w1 ^ f0;
        f2 = w2 ^ f1;
        rk_fwd = {f0, f1, f2, w3 ^ f2};
        rk_inv = {w0 ^ inv_sub ^ {rcon_reg, 24'h0}, w1 ^ w0, w2 ^ w1, inv_w3};
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        st_next    = st_reg;
        c_lat_next = c_lat_reg;
        rk_next    = rk_reg;
        rcon_next  = rcon_reg;
        chain_next = chain_reg;
        pt_next    = pt_reg;
        case (state_reg)
            S_LOAD: begin
                st_next    = ciphertext;
                c_lat_next = ciphertext;
                rk_next    = key;
                rcon_next  = 8'h01;
                cnt_next   = 4'd0;
                state_next = S_EXPAND;
            end
            S_EXPAND: begin
                rk_next   = rk_fwd;
                rcon_next = xtime(rcon_reg);
                cnt_next  = cnt_reg + 4'd1;
                if (cnt_reg == 4'd9) begin
                    state_next = S_TURN;
                end
            end
            S_TURN: begin
                // rk already holds RK10; rcon is reset to the value that
                // produced RK10 so the backward walk starts aligned.
                rcon_next  = 8'h36;
                state_next = S_ARK;
            end
            S_ARK: begin
                st_next    = st_reg ^ rk_reg;
                rk_next    = rk_inv;
                rcon_next  = inv_xtime(rcon_reg);
                cnt_next   = 4'd0;
                state_next = S_ROUND;
            end
            S_ROUND: begin
                st_next   = inv_mix_columns(st_subbed ^ rk_reg);
                rk_next   = rk_inv;
                rcon_next = inv_xtime(rcon_reg);
                cnt_next  = cnt_reg + 4'd1;
                if (cnt_reg == 4'd8) begin
                    state_next = S_FINAL;
                end
            end
            S_FINAL: begin
                pt_next    = st_subbed ^ rk_reg ^ chain_reg;
                chain_next = c_lat_reg;
                state_next = S_LOAD;
            end
            default: state_next = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_LOAD;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pt_reg    <= '0;
            chain_reg <= iv;
        end else begin
            pt_reg    <= pt_next;
            chain_reg <= chain_next;
        end
    end

    // Working registers need no reset: LOAD always initialises them.
    always_ff @(posedge clk) begin
        cnt_reg   <= cnt_next;
        st_reg    <= st_next;
        c_lat_reg <= c_lat_next;
        rk_reg    <= rk_next;
        rcon_reg  <= rcon_next;
    end

    assign plaintext = pt_reg;

endmodule

// File: tb/tb_aes128_cbc_decrypt.sv
// ---------------------------------------------------------------------------
// tb_aes128_cbc_decrypt
//   Self-checking bench for aes128_cbc_decrypt. Known-answer vectors come
//   from a table. Randomised CBC streams are checked against a byte-level
//   AES model, whose S-boxes are derived from GF(2^8) inversion.
//   A block is 23 clocks: the LOAD edge is edge 1, and plaintext changes on
//   edge 23.
// ---------------------------------------------------------------------------
module tb_aes128_cbc_decrypt;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [127:0] ciphertext = '0;
    logic [127:0] key = '0;
    logic [127:0] iv = '0;
    logic [127:0] plaintext;

    always #5 clk = ~clk;

    aes128_cbc_decrypt dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ciphertext (ciphertext),
        .key        (key),
        .iv         (iv),
        .plaintext  (plaintext)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sbox [256];
    logic [7:0] inv_sbox [256];

    typedef struct packed {
        logic [127:0] key;
        logic [127:0] ct;
        logic [127:0] iv;
        logic [127:0] exp1;   // first block after reset
        logic [127:0] exp2;   // second block, same inputs held
    } vec_t;

    vec_t vecs [3];

    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] IV2 = 128'h1234567890abcdef1234567890abcdef;
    localparam logic [127:0] P2  = 128'h1225744bd4feab989aadfcc35c762310;
    localparam logic [127:0] P3  = 128'h69d5c2eb2e2e624750541d3bbc692ba5;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_sboxes();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            if (x == 0) inv = 8'h00;
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[x]     = s;
            inv_sbox[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] ref_decrypt(input logic [127:0] k, input logic [127:0] c);
        logic [7:0] w [44][4];
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [7:0] tmp [4];
        logic [7:0] a [4];
        logic [7:0] rc;
        logic [127:0] o;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                w[i][j] = k[127 - 8*(4*i + j) -: 8];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-1][j];
            if (i % 4 == 0) begin
                tmp[0] = sbox[w[i-1][1]] ^ rc;
                tmp[1] = sbox[w[i-1][2]];
                tmp[2] = sbox[w[i-1][3]];
                tmp[3] = sbox[w[i-1][0]];
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ tmp[j];
        end
        for (int r = 0; r < 4; r++)
            for (int cc = 0; cc < 4; cc++)
                s[r][cc] = c[127 - 8*(r + 4*cc) -: 8] ^ w[40 + cc][r];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int r = 0; r < 4; r++)
                for (int cc = 0; cc < 4; cc++)
                    t[r][(cc + r) % 4] = inv_sbox[s[r][cc]];
            for (int r = 0; r < 4; r++)
                for (int cc = 0; cc < 4; cc++)
                    s[r][cc] = t[r][cc] ^ w[4*rnd + cc][r];
            if (rnd > 0) begin
                for (int cc = 0; cc < 4; cc++) begin
                    for (int r = 0; r < 4; r++) a[r] = s[r][cc];
                    s[0][cc] = gmul(a[0],8'h0e) ^ gmul(a[1],8'h0b) ^ gmul(a[2],8'h0d) ^ gmul(a[3],8'h09);
                    s[1][cc] = gmul(a[0],8'h09) ^ gmul(a[1],8'h0e) ^ gmul(a[2],8'h0b) ^ gmul(a[3],8'h0d);
                    s[2][cc] = gmul(a[0],8'h0d) ^ gmul(a[1],8'h09) ^ gmul(a[2],8'h0e) ^ gmul(a[3],8'h0b);
                    s[3][cc] = gmul(a[0],8'h0b) ^ gmul(a[1],8'h0d) ^ gmul(a[2],8'h09) ^ gmul(a[3],8'h0e);
                end
            end
        end
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int cc = 0; cc < 4; cc++)
                o[127 - 8*(r + 4*cc) -: 8] = s[r][cc];
        return o;
    endfunction

    // ---------------- helpers ----------------
    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check128(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: plaintext=%h expected=%h", tag, act, exp);
        end else begin
            $display("ok   %s: plaintext=%h", tag, act);
        end
    endtask

    // Reset for one clock with the given iv, then release. After release,
    // iv is scrambled: it must be ignored from then on.
    task automatic do_reset(input logic [127:0] iv_val);
        rst_n = 1'b0;
        iv    = iv_val;
        tick();
        check128("reset_clear", plaintext, 128'h0);
        rst_n = 1'b1;
        iv    = rand128();
    endtask

    // Runs one block starting at its LOAD edge. plaintext must hold for
    // edges 1..22 and show exp after edge 23. With perturb set, key and
    // ciphertext are scrambled after edge 5.
    task automatic run_block(input logic [127:0] exp, input string tag, input bit perturb);
        logic [127:0] held;
        int first_change;
        held = plaintext;
        first_change = 0;
        for (int k = 1; k <= 22; k++) begin
            tick();
            if (perturb && k == 5) begin
                key        = rand128();
                ciphertext = rand128();
            end
            if (plaintext !== held && first_change == 0) first_change = k;
        end
        n_checks++;
        if (first_change != 0) begin
            n_fail++;
            $display("FAIL %s_hold: plaintext changed at edge %0d, required stable until edge 23",
                     tag, first_change);
        end
        tick();
        check128(tag, plaintext, exp);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [127:0] chain, prev_ct, exp;
        build_sboxes();

        vecs[0].key = K1; vecs[0].ct = C1; vecs[0].iv = '0;
        vecs[0].exp1 = P1; vecs[0].exp2 = P3;
        vecs[1].key = K1; vecs[1].ct = C1; vecs[1].iv = IV2;
        vecs[1].exp1 = P2; vecs[1].exp2 = P3;
        vecs[2].key  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        vecs[2].ct   = 128'h7649abac8119b246cee98e9b12e9197d;
        vecs[2].iv   = 128'h000102030405060708090a0b0c0d0e0f;
        vecs[2].exp1 = 128'h6bc1bee22e409f96e93d7e117393172a;
        vecs[2].exp2 = 128'h1d89174dab5c2bd72fddfa816d770058;

        for (int i = 0; i < 3; i++) begin
            key        = vecs[i].key;
            ciphertext = vecs[i].ct;
            do_reset(vecs[i].iv);
            run_block(vecs[i].exp1, $sformatf("vec%0d_blk1", i), 1'b0);
            run_block(vecs[i].exp2, $sformatf("vec%0d_blk2", i), 1'b0);
        end

        // Mid-block reset: abort a running block, then restart with iv = 0.
        key = K1; ciphertext = C1;
        do_reset(IV2);
        run_block(P2, "abort_pre", 1'b0);
        repeat (10) tick();
        check128("abort_no_partial", plaintext, P2);
        rst_n = 1'b0;
        iv    = '0;
        tick();
        check128("abort_clear", plaintext, 128'h0);
        rst_n = 1'b1;
        iv    = rand128();
        run_block(P1, "abort_restart", 1'b0);

        // Input isolation: changes mid-block only apply from the next LOAD.
        key = K1; ciphertext = C1;
        do_reset(IV2);
        run_block(P2, "isolate_blk1", 1'b1);
        exp = ref_decrypt(key, ciphertext) ^ C1;
        run_block(exp, "isolate_blk2", 1'b0);

        // Randomised CBC stream against the model.
        chain = rand128();
        key = rand128();
        ciphertext = rand128();
        do_reset(chain);
        prev_ct = '0;
        for (int b = 0; b < 8; b++) begin
            if (b % 3 == 0) key = rand128();
            ciphertext = (b == 4) ? prev_ct : rand128();
            exp     = ref_decrypt(key, ciphertext) ^ chain;
            chain   = ciphertext;
            prev_ct = ciphertext;
            run_block(exp, $sformatf("rand_blk%0d", b), b[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
